// File: rtl/tpu_seq_ctrl.sv
// tpu_seq_ctrl: load/feed/drain sequencer for an NxN systolic matrix-multiply unit
module tpu_seq_ctrl #(
  parameter int N        = 2,
  parameter int AW       = $clog2(2*N*N),
  parameter int FEED_LEN = 3*N-2,
  parameter int CW       = $clog2(FEED_LEN),
  parameter int OW       = $clog2(N*N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          reuse_b,
  input  logic          abort,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          wm_load,
  output logic [AW-1:0] wm_addr,
  output logic          feeding_en,
  output logic [CW-1:0] feed_step,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_idx,
  output logic          busy,
  output logic          done
);
  typedef enum logic [1:0] {IDLE, LOAD, FEED, DRAIN} state_t;
  state_t        state;
  logic [AW-1:0] load_cnt;
  logic [AW-1:0] load_last;
  logic          reuse_q;
  assign in_ready   = state == LOAD;
  assign wm_load    = in_ready & in_valid;
  assign wm_addr    = load_cnt;
  assign feeding_en = state == FEED;
  assign out_valid  = state == DRAIN;
  assign busy       = state != IDLE;
  // with B reused only the A region is reloaded
  assign load_last  = reuse_q ? AW'(N*N-1) : AW'(2*N*N-1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      load_cnt  <= '0;
      feed_step <= '0;
      out_idx   <= '0;
      reuse_q   <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        load_cnt  <= '0;
        feed_step <= '0;
        out_idx   <= '0;
      end else begin
        case (state)
          IDLE: if (start) begin
            state   <= LOAD;
            reuse_q <= reuse_b;
          end
          LOAD: if (in_valid) begin
            state    <= (load_cnt == load_last) ? FEED : LOAD;
            load_cnt <= (load_cnt == load_last) ? '0 : load_cnt + 1'b1;
          end
          FEED: begin
            state     <= (feed_step == CW'(FEED_LEN-1)) ? DRAIN : FEED;
            feed_step <= (feed_step == CW'(FEED_LEN-1)) ? '0 : feed_step + 1'b1;
          end
          DRAIN: if (out_ready) begin
            state   <= (out_idx == OW'(N*N-1)) ? IDLE : DRAIN;
            out_idx <= (out_idx == OW'(N*N-1)) ? '0 : out_idx + 1'b1;
            done    <= out_idx == OW'(N*N-1);
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_tpu_seq_ctrl.sv
// tb_tpu_seq_ctrl: directed bench for N=2 and N=3 instances against a transaction-level model
module tb_tpu_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, reuse_b = 1'b0, abort = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic ir0, wl0, fe0, ov0, bz0, dn0;
  logic [2:0] wa0;
  logic [1:0] fs0, oi0;
  logic ir1, wl1, fe1, ov1, bz1, dn1;
  logic [4:0] wa1;
  logic [2:0] fs1;
  logic [3:0] oi1;
  int checks = 0, failures = 0;
  int cyc = 0;
  bit chk_on = 1'b0;
  int mode[2] = '{0, 0};
  int c_load[2] = '{0, 0};
  int c_feed[2] = '{0, 0};
  int c_out[2] = '{0, 0};
  bit reuse_m[2] = '{0, 0};
  bit done_m[2] = '{0, 0};
  int addr_q[$], acc_q[$], addr3_q[$], acc3_q[$];
  int feed_n = 0, feed3_n = 0;
  int first_feed_cyc = -1, last_load_cyc = -1, last_acc_cyc = -1, done_cyc = -1;
  int start_cyc = 0;

  tpu_seq_ctrl #(.N(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .reuse_b(reuse_b), .abort(abort),
    .in_valid(in_valid), .in_ready(ir0), .wm_load(wl0), .wm_addr(wa0),
    .feeding_en(fe0), .feed_step(fs0), .out_valid(ov0), .out_ready(out_ready),
    .out_idx(oi0), .busy(bz0), .done(dn0)
  );
  tpu_seq_ctrl #(.N(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .reuse_b(reuse_b), .abort(abort),
    .in_valid(in_valid), .in_ready(ir1), .wm_load(wl1), .wm_addr(wa1),
    .feeding_en(fe1), .feed_step(fs1), .out_valid(ov1), .out_ready(out_ready),
    .out_idx(oi1), .busy(bz1), .done(dn1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int nn(input int k);
    return (k == 0) ? 2 : 3;
  endfunction

  // model: phase plus "elements done so far" per phase, per instance
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        mode[k] <= 0; c_load[k] <= 0; c_feed[k] <= 0; c_out[k] <= 0;
        reuse_m[k] <= 1'b0; done_m[k] <= 1'b0;
      end else begin
        done_m[k] <= 1'b0;
        if (abort) begin
          mode[k] <= 0; c_load[k] <= 0; c_feed[k] <= 0; c_out[k] <= 0;
        end else if (mode[k] == 0) begin
          if (start) begin mode[k] <= 1; reuse_m[k] <= reuse_b; end
        end else if (mode[k] == 1) begin
          if (in_valid) begin
            if (c_load[k] + 1 == (reuse_m[k] ? 1 : 2) * nn(k) * nn(k)) begin
              mode[k] <= 2; c_load[k] <= 0;
            end else c_load[k] <= c_load[k] + 1;
          end
        end else if (mode[k] == 2) begin
          if (c_feed[k] + 1 == 3 * nn(k) - 2) begin
            mode[k] <= 3; c_feed[k] <= 0;
          end else c_feed[k] <= c_feed[k] + 1;
        end else if (out_ready) begin
          if (c_out[k] + 1 == nn(k) * nn(k)) begin
            mode[k] <= 0; c_out[k] <= 0; done_m[k] <= 1'b1;
          end else c_out[k] <= c_out[k] + 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_seq(input string nm, input int q[$], input int n);
    chk({nm, "_len"}, q.size(), n);
    for (int i = 0; i < q.size() && i < n; i++) chk(nm, q[i], i);
  endtask

  task automatic cmp(input int k, input int ir, input int wl, input int wa, input int fe,
                     input int fs, input int ov, input int oi, input int bz, input int dn);
    string p;
    p = (k == 0) ? "n2" : "n3";
    chk({p, "_in_ready"}, ir, int'(mode[k] == 1));
    chk({p, "_wm_load"}, wl, int'(mode[k] == 1 && in_valid));
    chk({p, "_wm_addr"}, wa, (mode[k] == 1) ? c_load[k] : 0);
    chk({p, "_feeding_en"}, fe, int'(mode[k] == 2));
    chk({p, "_feed_step"}, fs, (mode[k] == 2) ? c_feed[k] : 0);
    chk({p, "_out_valid"}, ov, int'(mode[k] == 3));
    chk({p, "_out_idx"}, oi, (mode[k] == 3) ? c_out[k] : 0);
    chk({p, "_busy"}, bz, int'(mode[k] != 0));
    chk({p, "_done"}, dn, int'(done_m[k]));
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp(0, int'(ir0), int'(wl0), int'(wa0), int'(fe0), int'(fs0), int'(ov0), int'(oi0), int'(bz0), int'(dn0));
      cmp(1, int'(ir1), int'(wl1), int'(wa1), int'(fe1), int'(fs1), int'(ov1), int'(oi1), int'(bz1), int'(dn1));
    end
    if (rst_n) begin
      if (wl0) begin addr_q.push_back(int'(wa0)); last_load_cyc = cyc; end
      if (fe0) begin feed_n++; if (first_feed_cyc < 0) first_feed_cyc = cyc; end
      if (ov0 && out_ready) begin acc_q.push_back(int'(oi0)); last_acc_cyc = cyc; end
      if (dn0) done_cyc = cyc;
      if (wl1) addr3_q.push_back(int'(wa1));
      if (fe1) feed3_n++;
      if (ov1 && out_ready) acc3_q.push_back(int'(oi1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    addr_q.delete(); acc_q.delete(); addr3_q.delete(); acc3_q.delete();
    feed_n = 0; feed3_n = 0;
    first_feed_cyc = -1; last_load_cyc = -1; last_acc_cyc = -1; done_cyc = -1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((bz0 || bz1) && t < 2000) begin tick(); t++; end
    chk("idle_timeout", int'(bz0 || bz1), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_in_ready"}, int'(ir0), 0);
    chk({tag, "_wm_load"}, int'(wl0), 0);
    chk({tag, "_wm_addr"}, int'(wa0), 0);
    chk({tag, "_feeding_en"}, int'(fe0), 0);
    chk({tag, "_feed_step"}, int'(fs0), 0);
    chk({tag, "_out_valid"}, int'(ov0), 0);
    chk({tag, "_out_idx"}, int'(oi0), 0);
    chk({tag, "_busy"}, int'(bz0), 0);
    chk({tag, "_done"}, int'(dn0), 0);
  endtask

  initial begin
    int t;
    repeat (2) tick();
    chk_on = 1'b1;
    tick();
    chk_zero("reset");
    rst_n = 1'b1;
    tick();
    // full operation with free-flowing handshakes
    in_valid = 1'b1; out_ready = 1'b1;
    clear_logs();
    pulse_start();
    wait_idle();
    chk_seq("t1_addr", addr_q, 8);
    chk("t1_feed_cycles", feed_n, 4);
    chk_seq("t1_out_idx", acc_q, 4);
    chk("t1_start_to_done", done_cyc - start_cyc + 1, 18);
    // in_valid toggling every cycle
    clear_logs();
    in_valid = 1'b0;
    pulse_start();
    t = 0;
    while (!fe0 && t < 100) begin in_valid = ~in_valid; tick(); t++; end
    chk("t2_reach_feed", int'(fe0), 1);
    in_valid = 1'b1;
    wait_idle();
    chk_seq("t2_addr", addr_q, 8);
    chk("t2_feed_after_last_load", first_feed_cyc - last_load_cyc, 1);
    // output backpressure at idx 2
    clear_logs();
    pulse_start();
    t = 0;
    while (!(ov0 && int'(oi0) == 2) && t < 100) begin tick(); t++; end
    chk("t3_reach_idx2", int'(ov0 && int'(oi0) == 2), 1);
    out_ready = 1'b0;
    repeat (3) begin
      tick();
      chk("t3_hold_idx", int'(oi0), 2);
      chk("t3_hold_valid", int'(ov0), 1);
    end
    chk("t3_no_early_done", done_cyc, -1);
    out_ready = 1'b1;
    wait_idle();
    chk_seq("t3_out_idx", acc_q, 4);
    chk("t3_done_after_last", done_cyc - last_acc_cyc, 1);
    // B reuse then full reload
    clear_logs();
    reuse_b = 1'b1;
    pulse_start();
    reuse_b = 1'b0;
    wait_idle();
    chk_seq("t4_reuse_addr", addr_q, 4);
    chk("t4_reuse_feed", feed_n, 4);
    clear_logs();
    pulse_start();
    wait_idle();
    chk_seq("t4_reload_addr", addr_q, 8);
    // abort in LOAD after 5 elements
    clear_logs();
    in_valid = 1'b0;
    pulse_start();
    in_valid = 1'b1;
    repeat (5) tick();
    in_valid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_zero("t5_load_abort");
    chk("t5_load_abort_n3_busy", int'(bz1), 0);
    chk("t5_loads_before_abort", addr_q.size(), 5);
    repeat (3) tick();
    chk("t5_load_abort_no_done", done_cyc, -1);
    clear_logs();
    in_valid = 1'b1;
    pulse_start();
    wait_idle();
    chk_seq("t5_clean1_addr", addr_q, 8);
    chk_seq("t5_clean1_out", acc_q, 4);
    // abort in DRAIN at idx 1
    clear_logs();
    pulse_start();
    t = 0;
    while (!(ov0 && int'(oi0) == 1) && t < 100) begin tick(); t++; end
    chk("t5_reach_idx1", int'(ov0 && int'(oi0) == 1), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_zero("t5_drain_abort");
    repeat (3) tick();
    chk("t5_drain_abort_no_done", done_cyc, -1);
    clear_logs();
    pulse_start();
    wait_idle();
    chk_seq("t5_clean2_addr", addr_q, 8);
    chk("t5_clean2_done", int'(done_cyc >= 0), 1);
    // start during FEED is ignored
    clear_logs();
    pulse_start();
    t = 0;
    while (!(fe0 && int'(fs0) == 1) && t < 100) begin tick(); t++; end
    chk("t6_reach_feed", int'(fe0), 1);
    pulse_start();
    wait_idle();
    chk_seq("t6_addr", addr_q, 8);
    chk("t6_feed_cycles", feed_n, 4);
    chk_seq("t6_out_idx", acc_q, 4);
    // asynchronous reset mid-FEED
    pulse_start();
    t = 0;
    while (!fe0 && t < 100) begin tick(); t++; end
    chk("t6_reach_feed2", int'(fe0), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_feeding_en", int'(fe0), 0);
    chk("t6_rst_busy", int'(bz0), 0);
    chk("t6_rst_n3_busy", int'(bz1), 0);
    tick();
    rst_n = 1'b1;
    tick();
    // N=3 instance full run
    clear_logs();
    pulse_start();
    wait_idle();
    chk_seq("t7_n3_addr", addr3_q, 18);
    chk("t7_n3_feed_cycles", feed3_n, 7);
    chk_seq("t7_n3_out_idx", acc3_q, 9);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
